// File: rtl/cla_nibble_sequencer_if.sv
// Requester, shared CLA slice and response signals of cla_nibble_sequencer.
// master = sequencer side, slave = requesters, CLA slice and consumer.
interface cla_nibble_sequencer_if #(
   parameter int WIDTH = 16
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req0_sub;
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             req1_sub;
   logic [3:0]       cla_a;
   logic [3:0]       cla_b;
   logic             cla_cin;
   logic [3:0]       cla_s;
   logic             cla_cout;
   logic             resp_valid;
   logic             resp_ready;
   logic             resp_id;
   logic [WIDTH-1:0] resp_sum;
   logic             resp_cout;
   logic             resp_ovf;

   modport master (
      input  req0_valid, req0_a, req0_b, req0_sub,
      input  req1_valid, req1_a, req1_b, req1_sub,
      output req0_ready, req1_ready,
      output cla_a, cla_b, cla_cin,
      input  cla_s, cla_cout,
      output resp_valid, resp_id, resp_sum, resp_cout, resp_ovf,
      input  resp_ready
   );

   modport slave (
      output req0_valid, req0_a, req0_b, req0_sub,
      output req1_valid, req1_a, req1_b, req1_sub,
      input  req0_ready, req1_ready,
      input  cla_a, cla_b, cla_cin,
      output cla_s, cla_cout,
      input  resp_valid, resp_id, resp_sum, resp_cout, resp_ovf,
      output resp_ready
   );
endinterface

// File: rtl/cla_nibble_sequencer.sv
// Two-requester arbiter that runs WIDTH-bit add/sub through one shared
// 4-bit CLA slice, one nibble per cycle with a registered carry.
module cla_nibble_sequencer #(
   parameter int WIDTH = 16
) (
   input logic                    clk,
   input logic                    rst_n,
   cla_nibble_sequencer_if.master bus
);
   localparam int NNIB = WIDTH / 4;
   localparam int IW = (NNIB > 1) ? $clog2(NNIB) : 1;
   localparam logic [IW-1:0] LAST = IW'(NNIB - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic [IW-1:0]    idx_q;
   logic             carry_q;
   logic             id_q;
   logic             prio_q;
   logic             vld_q;
   logic             rid_q;
   logic             cout_q;
   logic             ovf_q;

   logic             gnt0;
   logic             gnt1;
   logic [WIDTH-1:0] a_d;
   logic [WIDTH-1:0] braw;
   logic [WIDTH-1:0] b_d;
   logic             sub_d;
   logic [IW+1:0]    lo;
   logic             run;

   // prio_q names the requester that wins a tie
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state_q == IDLE) begin
         gnt0 = bus.req0_valid && (!bus.req1_valid || !prio_q);
         gnt1 = bus.req1_valid && (!bus.req0_valid || prio_q);
      end
   end

   assign a_d   = gnt1 ? bus.req1_a : bus.req0_a;
   assign braw  = gnt1 ? bus.req1_b : bus.req0_b;
   assign sub_d = gnt1 ? bus.req1_sub : bus.req0_sub;
   assign b_d   = sub_d ? ~braw : braw;
   assign lo    = {idx_q, 2'b00};
   assign run   = (state_q == RUN);

   assign bus.req0_ready = gnt0;
   assign bus.req1_ready = gnt1;
   assign bus.cla_a      = run ? a_q[lo +: 4] : 4'h0;
   assign bus.cla_b      = run ? b_q[lo +: 4] : 4'h0;
   assign bus.cla_cin    = run ? carry_q : 1'b0;
   assign bus.resp_valid = vld_q;
   assign bus.resp_id    = rid_q;
   assign bus.resp_sum   = sum_q;
   assign bus.resp_cout  = cout_q;
   assign bus.resp_ovf   = ovf_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         id_q    <= 1'b0;
         prio_q  <= 1'b0;
         vld_q   <= 1'b0;
         rid_q   <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (gnt0 || gnt1) begin
                  a_q     <= a_d;
                  b_q     <= b_d;
                  id_q    <= gnt1;
                  carry_q <= sub_d;
                  idx_q   <= '0;
                  prio_q  <= !gnt1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               sum_q[lo +: 4] <= bus.cla_s;
               carry_q        <= bus.cla_cout;
               idx_q          <= idx_q + IW'(1);
               if (idx_q == LAST) begin
                  idx_q   <= '0;
                  cout_q  <= bus.cla_cout;
                  ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                             (bus.cla_s[3] != a_q[WIDTH-1]);
                  rid_q   <= id_q;
                  vld_q   <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (bus.resp_ready) begin
                  vld_q   <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Bench for cla_nibble_sequencer: directed vectors, arbitration,
// backpressure, mid-run reset and random ops against an arithmetic model.
module tb_cla_nibble_sequencer;
   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   int   cyc;

   cla_nibble_sequencer_if #(.WIDTH(16)) bif ();

   cla_nibble_sequencer #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   // the external 4-bit CLA slice
   always_comb begin
      {bif.cla_cout, bif.cla_s} = {1'b0, bif.cla_a} + {1'b0, bif.cla_b}
                                  + {4'b0, bif.cla_cin};
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          id;
      logic [15:0] a;
      logic [15:0] b;
      bit          sub;
      logic [15:0] sum;
      bit          cout;
      bit          ovf;
      logic [3:0]  cin;
      int          bp;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // {ovf, cout, sum} from plain integer arithmetic
   function automatic logic [17:0] ref_op(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic sub);
      int          sa;
      int          sb;
      int          r;
      logic [16:0] u;
      logic        c;
      logic        o;
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sub) begin
         r = sa - sb;
         u = {1'b0, a - b};
         c = (a >= b);
      end else begin
         r = sa + sb;
         u = {1'b0, a} + {1'b0, b};
         c = u[16];
      end
      o = (r > 32767) || (r < -32768);
      return {o, c, u[15:0]};
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      bif.req0_valid = 1'b0;
      bif.req1_valid = 1'b0;
      bif.resp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic run_op(input bit id, input logic [15:0] a,
                         input logic [15:0] b, input bit sub,
                         input bit chk_cin, input logic [3:0] exp_cin,
                         input int bp, output logic [15:0] sum,
                         output logic cout, output logic ovf,
                         output logic rid);
      logic [15:0] bb;
      bb = sub ? ~b : b;
      if (id) begin
         bif.req1_a = a;
         bif.req1_b = b;
         bif.req1_sub = sub;
      end else begin
         bif.req0_a = a;
         bif.req0_b = b;
         bif.req0_sub = sub;
      end
      bif.req0_valid = !id;
      bif.req1_valid = id;
      #1;
      chk("grant_rdy0", bif.req0_ready, !id);
      chk("grant_rdy1", bif.req1_ready, id);
      @(posedge clk);
      #1;
      bif.req0_valid = 1'b0;
      bif.req1_valid = 1'b0;
      bif.req0_a = 16'($urandom);
      bif.req1_a = 16'($urandom);
      bif.req0_b = 16'($urandom);
      bif.req1_b = 16'($urandom);
      for (int k = 0; k < 4; k++) begin
         chk("run_cla_a", bif.cla_a, a[4*k +: 4]);
         chk("run_cla_b", bif.cla_b, bb[4*k +: 4]);
         if (chk_cin) chk("run_cin", bif.cla_cin, exp_cin[k]);
         chk("run_rdy", {bif.req0_ready, bif.req1_ready}, 0);
         chk("run_vld", bif.resp_valid, 0);
         @(posedge clk);
         #1;
      end
      chk("latency_vld", bif.resp_valid, 1);
      sum = bif.resp_sum;
      cout = bif.resp_cout;
      ovf = bif.resp_ovf;
      rid = bif.resp_id;
      bif.req0_valid = 1'b1;
      for (int j = 0; j < bp; j++) begin
         @(posedge clk);
         #1;
         chk("bp_vld", bif.resp_valid, 1);
         chk("bp_sum", bif.resp_sum, sum);
         chk("bp_flags", {bif.resp_id, bif.resp_cout, bif.resp_ovf},
             {rid, cout, ovf});
         chk("bp_rdy", {bif.req0_ready, bif.req1_ready}, 0);
         chk("bp_cla", {bif.cla_a, bif.cla_b, bif.cla_cin}, 0);
      end
      bif.resp_ready = 1'b1;
      #1;
      chk("handoff_rdy", {bif.req0_ready, bif.req1_ready}, 0);
      @(posedge clk);
      #1;
      bif.resp_ready = 1'b0;
      bif.req0_valid = 1'b0;
      chk("handoff_vld", bif.resp_valid, 0);
      chk("hold_sum", bif.resp_sum, sum);
      chk("idle_cla", {bif.cla_a, bif.cla_b, bif.cla_cin}, 0);
   endtask

   vec_t        vt[6];
   logic [15:0] s;
   logic        co;
   logic        ov;
   logic        ri;
   logic [17:0] exp;
   int          last_cyc;
   int          w;

   initial begin
      n_tests = 0;
      n_fail = 0;
      cyc = 0;
      bif.req0_a = '0;
      bif.req0_b = '0;
      bif.req0_sub = 1'b0;
      bif.req1_a = '0;
      bif.req1_b = '0;
      bif.req1_sub = 1'b0;
      vt[0] = '{0, 16'h1234, 16'h0FFF, 0, 16'h2233, 0, 0, 4'b1110, 0};
      vt[1] = '{0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0, 4'b1110, 1};
      vt[2] = '{1, 16'h8000, 16'h0001, 1, 16'h7FFF, 1, 1, 4'b0001, 3};
      vt[3] = '{1, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1, 4'b1110, 0};
      vt[4] = '{0, 16'h0000, 16'h0001, 1, 16'hFFFF, 0, 0, 4'b0001, 2};
      vt[5] = '{1, 16'h1234, 16'h1234, 1, 16'h0000, 1, 0, 4'b1111, 0};

      do_reset();
      chk("rst_rdy", {bif.req0_ready, bif.req1_ready}, 0);
      chk("rst_resp", {bif.resp_valid, bif.resp_id, bif.resp_cout,
                       bif.resp_ovf}, 0);
      chk("rst_sum", bif.resp_sum, 0);
      chk("rst_cla", {bif.cla_a, bif.cla_b, bif.cla_cin}, 0);

      // both requesters hold valid: expect strict alternation
      bif.resp_ready = 1'b1;
      bif.req0_valid = 1'b1;
      bif.req1_valid = 1'b1;
      last_cyc = 0;
      for (int g = 0; g < 4; g++) begin
         #1;
         w = 0;
         while (!(bif.req0_ready || bif.req1_ready) && w < 20) begin
            @(posedge clk);
            #1;
            w++;
         end
         chk("arb_timeout", (w < 20), 1);
         chk("arb_onehot", bif.req0_ready && bif.req1_ready, 0);
         chk("arb_order", {bif.req0_ready, bif.req1_ready},
             (g % 2 == 0) ? 2'b10 : 2'b01);
         if (g > 0) chk("arb_gap", cyc - last_cyc, 6);
         last_cyc = cyc;
         @(posedge clk);
      end
      #1;
      bif.req0_valid = 1'b0;
      bif.req1_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      bif.resp_ready = 1'b0;

      do_reset();
      for (int i = 0; i < 6; i++) begin
         run_op(vt[i].id, vt[i].a, vt[i].b, vt[i].sub, 1'b1, vt[i].cin,
                vt[i].bp, s, co, ov, ri);
         chk("vec_sum", s, vt[i].sum);
         chk("vec_cout", co, vt[i].cout);
         chk("vec_ovf", ov, vt[i].ovf);
         chk("vec_id", ri, vt[i].id);
      end

      for (int i = 0; i < 40; i++) begin
         logic        rid;
         logic [15:0] ra;
         logic [15:0] rb;
         logic        rs;
         rid = 1'($urandom);
         ra = 16'($urandom);
         rb = 16'($urandom);
         rs = 1'($urandom);
         exp = ref_op(ra, rb, rs);
         run_op(rid, ra, rb, rs, 1'b0, 4'h0, int'($urandom_range(0, 2)),
                s, co, ov, ri);
         chk("rnd_sum", s, exp[15:0]);
         chk("rnd_cout", co, exp[16]);
         chk("rnd_ovf", ov, exp[17]);
         chk("rnd_id", ri, rid);
      end

      // reset during RUN nibble 2 after a req0 grant
      bif.req0_a = 16'h1111;
      bif.req0_b = 16'h2222;
      bif.req0_sub = 1'b0;
      bif.req0_valid = 1'b1;
      bif.req1_valid = 1'b0;
      #1;
      chk("mid_rdy", bif.req0_ready, 1);
      @(posedge clk);
      #1;
      bif.req0_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("mid_k2_cla_b", bif.cla_b, 4'h2);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_vld", bif.resp_valid, 0);
      chk("mid_rst_cla", {bif.cla_a, bif.cla_b, bif.cla_cin}, 0);
      chk("mid_rst_rdy", {bif.req0_ready, bif.req1_ready}, 0);
      rst_n = 1'b1;
      bif.req0_valid = 1'b1;
      bif.req1_valid = 1'b1;
      #1;
      chk("post_rst_tie", {bif.req0_ready, bif.req1_ready}, 2'b10);
      bif.req0_valid = 1'b0;
      bif.req1_valid = 1'b0;
      run_op(0, 16'h00F0, 16'h0010, 0, 1'b1, 4'b0100, 0, s, co, ov, ri);
      chk("post_rst_sum", s, 16'h0100);
      chk("post_rst_flags", {co, ov, ri}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
